// File: rtl/cache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : cache_pkg                                                  |
// | Purpose : Geometry constants and refill state encoding shared by the |
// |           direct-mapped cache and its backing refill memory.         |
// | Ports   : none                                                       |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package cache_pkg;

  localparam int WORD_SIZE   = 32;                            // bits per word
  localparam int WORD_COUNT  = 4;                             // words per line
  localparam int OFFSET_SIZE = 2;                             // log2(WORD_COUNT)
  localparam int ADDR_SIZE   = 15;                            // word address bits
  localparam int INDEX_SIZE  = 8;                             // cache set index bits
  localparam int TAG_SIZE    = ADDR_SIZE - OFFSET_SIZE - INDEX_SIZE;
  localparam int LINE_BITS   = WORD_SIZE * WORD_COUNT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } refill_state_t;

endpackage
`default_nettype wire

// File: rtl/cache_refill_memory_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : cache_refill_memory_if                                   |
// | Purpose   : Refill request/response bus plus preload write port.     |
// | Signals   : req, blk_addr         -> refill request (master drives)  |
// |             req_accept, busy      <- request handshake / status      |
// |             line_valid, line_data <- assembled line                  |
// |             init_we/addr/data     -> preload write                   |
// | Modports  : master (cache / bench), slave (refill memory)            |
// | Rev       : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
interface cache_refill_memory_if
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_SIZE,
  parameter int WORD_WIDTH     = WORD_SIZE,
  parameter int WORDS_PER_LINE = WORD_COUNT,
  parameter int OFFSET_WIDTH   = OFFSET_SIZE
);

  logic                                   req;
  logic [ADDR_WIDTH-OFFSET_WIDTH-1:0]     blk_addr;
  logic                                   req_accept;
  logic                                   busy;
  logic                                   line_valid;
  logic [WORD_WIDTH*WORDS_PER_LINE-1:0]   line_data;
  logic                                   init_we;
  logic [ADDR_WIDTH-1:0]                  init_addr;
  logic [WORD_WIDTH-1:0]                  init_data;

  modport master (
    output req, blk_addr, init_we, init_addr, init_data,
    input  req_accept, busy, line_valid, line_data
  );

  modport slave (
    input  req, blk_addr, init_we, init_addr, init_data,
    output req_accept, busy, line_valid, line_data
  );

endinterface
`default_nettype wire

// File: rtl/refill_word_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : refill_word_ram                                            |
// | Purpose : 2**ADDR_WIDTH x WORD_WIDTH main memory array.              |
// |           Synchronous write, asynchronous (combinational) read.      |
// |           Contents are not reset.                                    |
// | Ports   : clk            clock, rising edge                          |
// |           we/waddr/wdata synchronous write port                      |
// |           raddr/rdata    combinational read port                     |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module refill_word_ram #(
  parameter int ADDR_WIDTH = 15,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WORD_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WORD_WIDTH-1:0] rdata
);

  logic [WORD_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/cache_refill_memory.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : cache_refill_memory                                        |
// | Purpose : Main memory + refill engine under the direct-mapped cache. |
// |           Accepts a line request, waits ACCESS_LATENCY cycles, reads |
// |           the line one word per cycle and presents it as one line    |
// |           {w3,w2,w1,w0}. Preload writes are taken only while idle.   |
// | Ports   : clk   clock, rising edge                                   |
// |           rst   asynchronous active-high reset                       |
// |           bus   cache_refill_memory_if.slave (request, response,     |
// |                 preload)                                             |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module cache_refill_memory
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_SIZE,
  parameter int WORD_WIDTH     = WORD_SIZE,
  parameter int WORDS_PER_LINE = WORD_COUNT,
  parameter int OFFSET_WIDTH   = OFFSET_SIZE,
  parameter int ACCESS_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  cache_refill_memory_if.slave  bus
);

  localparam int BLK_WIDTH  = ADDR_WIDTH - OFFSET_WIDTH;
  localparam int LINE_WIDTH = WORD_WIDTH * WORDS_PER_LINE;
  localparam logic [7:0]              LAT_LOAD = 8'(ACCESS_LATENCY - 1);
  localparam logic [OFFSET_WIDTH-1:0] LAST_K   = OFFSET_WIDTH'(WORDS_PER_LINE - 1);

  generate
    if (ACCESS_LATENCY < 1 || ACCESS_LATENCY > 255) begin : g_bad_latency
      $error("cache_refill_memory: ACCESS_LATENCY must be in 1..255");
    end
    if (WORDS_PER_LINE != (2 ** OFFSET_WIDTH)) begin : g_bad_geometry
      $error("cache_refill_memory: WORDS_PER_LINE must equal 2**OFFSET_WIDTH");
    end
  endgenerate

  refill_state_t            state_q, state_d;
  logic [7:0]               cnt_q, cnt_d;
  logic [OFFSET_WIDTH-1:0]  k_q, k_d;
  logic [BLK_WIDTH-1:0]     blk_q;
  logic [LINE_WIDTH-1:0]    line_q;
  logic                     accept_q;

  logic                     in_idle;
  logic                     accept;
  logic                     ram_we;
  logic [ADDR_WIDTH-1:0]    rd_addr;
  logic [WORD_WIDTH-1:0]    rd_data;

  // Preload has priority over a request in the same idle cycle; both are
  // ignored outside IDLE so the line being fetched cannot change underneath.
  assign in_idle = (state_q == IDLE);
  assign accept  = in_idle & bus.req & ~bus.init_we;
  assign ram_we  = in_idle & bus.init_we;
  // Offset is concatenated, not added: a line never crosses into the next.
  assign rd_addr = {blk_q, k_q};

  refill_word_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WORD_WIDTH (WORD_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (bus.init_addr),
    .wdata (bus.init_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WAIT;
          cnt_d   = LAT_LOAD;
          k_d     = '0;
        end
      end
      WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d = BURST;
          k_d     = '0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      BURST: begin
        if (k_q == LAST_K) begin
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      k_q      <= '0;
      blk_q    <= '0;
      line_q   <= '0;
      accept_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      accept_q <= accept;
      if (accept) begin
        blk_q  <= bus.blk_addr;
        line_q <= '0;  // partial lines never expose a previous line's words
      end else if (state_q == BURST) begin
        line_q[k_q*WORD_WIDTH +: WORD_WIDTH] <= rd_data;
      end
    end
  end

  assign bus.req_accept = accept_q;
  assign bus.busy       = ~in_idle;
  assign bus.line_valid = (state_q == DONE);
  assign bus.line_data  = line_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_refill_memory.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_cache_refill_memory                                     |
// | Purpose : Self-checking bench for cache_refill_memory. Directed      |
// |           steps push expected accept cycles and lines into queues;   |
// |           a negedge monitor pops and compares when the DUT responds. |
// | Ports   : none                                                       |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_cache_refill_memory;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;

  typedef struct {
    logic [127:0] line;
    int           cyc;
  } exp_line_t;

  exp_line_t    line_q[$];
  int           acc_q[$];
  logic [31:0]  mem_model [int];

  cache_refill_memory_if bus ();

  cache_refill_memory dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic init_write(input logic [14:0] addr, input logic [31:0] data);
    bus.init_we   = 1'b1;
    bus.init_addr = addr;
    bus.init_data = data;
    mem_model[int'(addr)] = data;
    tick();
    bus.init_we = 1'b0;
  endtask

  function automatic logic [127:0] model_line(input int blk);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = mem_model[blk*4 + k];
    return l;
  endfunction

  function automatic exp_line_t mk(input logic [127:0] l, input int c);
    exp_line_t e;
    e.line = l;
    e.cyc  = c;
    return e;
  endfunction

  // Response monitor: every accept / line_valid must match a queued expectation.
  always @(negedge clk) begin : mon
    exp_line_t e;
    int        ec;
    if (!rst) begin
      if (bus.req_accept === 1'b1) begin
        ec = (acc_q.size() != 0) ? acc_q.pop_front() : -1;
        chk_int("accept_cycle", cyc, ec);
      end
      if (bus.line_valid === 1'b1) begin
        if (line_q.size() != 0) e = line_q.pop_front();
        else                    e = mk('0, -1);
        chk_int("line_valid_cycle", cyc, e.cyc);
        chk("line_data", bus.line_data, e.line);
      end
    end
  end

  initial begin : stim
    int c;
    logic [127:0] basic_line;
    basic_line = 128'h000000A3_000000A2_000000A1_000000A0;
    total = 0;
    bad   = 0;
    cyc   = 0;
    rst           = 1'b1;
    bus.req       = 1'b0;
    bus.blk_addr  = '0;
    bus.init_we   = 1'b0;
    bus.init_addr = '0;
    bus.init_data = '0;

    // 1: reset state and idle
    tick(2);
    chk("rst_req_accept", {127'd0, bus.req_accept}, 128'd0);
    chk("rst_busy",       {127'd0, bus.busy},       128'd0);
    chk("rst_line_valid", {127'd0, bus.line_valid}, 128'd0);
    chk("rst_line_data",  bus.line_data,            128'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_busy", {127'd0, bus.busy}, 128'd0);
    end

    // 2: basic refill of block 0x400
    for (int i = 0; i < 4; i++) init_write(15'h1000 + 15'(i), 32'hA0 + 32'(i));
    c = cyc;
    bus.req = 1'b1;
    bus.blk_addr = 13'h400;
    acc_q.push_back(c + 1);
    line_q.push_back(mk(basic_line, c + 9));
    tick();
    bus.req = 1'b0;
    chk("basic_busy_c1", {127'd0, bus.busy}, 128'd1);
    tick(8);
    chk("basic_busy_c9", {127'd0, bus.busy}, 128'd1);
    tick();
    chk("basic_busy_c10", {127'd0, bus.busy}, 128'd0);
    chk("basic_held_data", bus.line_data, basic_line);
    chk_int("basic_pending", line_q.size(), 0);

    // 3: back-to-back with req held, second block at top of memory
    for (int i = 0; i < 4; i++) init_write(15'(i), 32'h1111_0000 + 32'(i));
    for (int i = 0; i < 4; i++) init_write(15'h7FFC + 15'(i), 32'hF0F0_0000 + 32'(i));
    c = cyc;
    bus.req = 1'b1;
    bus.blk_addr = 13'h000;
    acc_q.push_back(c + 1);
    line_q.push_back(mk(model_line(0), c + 9));
    tick();
    bus.blk_addr = 13'h1FFF;
    acc_q.push_back(c + 11);
    line_q.push_back(mk(128'hF0F00003_F0F00002_F0F00001_F0F00000, c + 19));
    tick(10);
    bus.req = 1'b0;
    tick(9);
    chk_int("b2b_pending", line_q.size() + acc_q.size(), 0);

    // 4: request pulse during WAIT is ignored
    for (int i = 0; i < 4; i++) init_write(15'h40 + 15'(i), 32'h4444_0000 + 32'(i));
    c = cyc;
    bus.req = 1'b1;
    bus.blk_addr = 13'h010;
    acc_q.push_back(c + 1);
    line_q.push_back(mk(model_line(16'h10), c + 9));
    tick();
    bus.req = 1'b0;
    tick();
    bus.req = 1'b1;
    bus.blk_addr = 13'h123;
    tick();
    bus.req = 1'b0;
    tick(8);
    chk("ignored_no_accept", {127'd0, bus.req_accept}, 128'd0);
    chk_int("ignored_pending", line_q.size() + acc_q.size(), 0);

    // 5: preload collisions
    for (int i = 0; i < 4; i++) init_write(15'h50 + 15'(i), 32'h5050_0000 + 32'(i));
    c = cyc;
    bus.init_we   = 1'b1;
    bus.init_addr = 15'h50;
    bus.init_data = 32'hDEADBEEF;
    mem_model[32'h50] = 32'hDEADBEEF;
    bus.req       = 1'b1;
    bus.blk_addr  = 13'h014;
    acc_q.push_back(c + 2);
    line_q.push_back(mk(model_line(16'h14), c + 10));
    tick();
    chk("collide_no_accept", {127'd0, bus.req_accept}, 128'd0);
    bus.init_we = 1'b0;
    tick();
    bus.req = 1'b0;
    tick(5);
    bus.init_we   = 1'b1;
    bus.init_addr = 15'h53;
    bus.init_data = 32'h55555555;
    tick();
    bus.init_we = 1'b0;
    tick(3);
    chk_int("collide_pending", line_q.size() + acc_q.size(), 0);
    chk("collide_line", bus.line_data, 128'h50500003_50500002_50500001_DEADBEEF);

    // 6: reset during BURST (k=2), then recovery
    c = cyc;
    bus.req = 1'b1;
    bus.blk_addr = 13'h010;
    acc_q.push_back(c + 1);
    tick();
    bus.req = 1'b0;
    tick(6);
    rst = 1'b1;
    #1;
    chk("abort_busy",       {127'd0, bus.busy},       128'd0);
    chk("abort_line_valid", {127'd0, bus.line_valid}, 128'd0);
    chk("abort_req_accept", {127'd0, bus.req_accept}, 128'd0);
    chk("abort_line_data",  bus.line_data,            128'd0);
    tick(2);
    rst = 1'b0;
    tick(10);
    c = cyc;
    bus.req = 1'b1;
    bus.blk_addr = 13'h400;
    acc_q.push_back(c + 1);
    line_q.push_back(mk(basic_line, c + 9));
    tick();
    bus.req = 1'b0;
    tick(10);
    chk_int("recover_pending", line_q.size() + acc_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
